// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

   localparam int UART_DATA_BITS  = 9;
   localparam int UART_OVERSAMPLE = 16;

   // Data bits XOR parity bit must equal this value for a good frame
   localparam logic PARITY_ODD = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx line synchronizer with falling-edge detect
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic rxs_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   // Shift the raw line into the chain, stage 0 first
   always_comb begin
      sync_d[0] = rx_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Chain and previous-sample flop preset to the idle-high line level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rxs_o  = sync_q[SYNC_STAGES-1];
   assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling 9-bit odd-parity UART receiver
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int DATA_BITS   = UART_DATA_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 rxclk,
   input  logic                 reset,
   input  logic                 rx_in,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_error,
   output logic                 rx_frame_error,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int IDX_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic rxs;
   logic fall;

   uart_state_e          state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_ok_q, par_ok_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 load;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (rxclk),
      .rst_i (reset),
      .rx_i  (rx_in),
      .rxs_o (rxs),
      .fall_o(fall)
   );

   // Frame FSM, bit counters and the output holding register next-state
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      data_d   = data_q;
      valid_d  = valid_q;
      err_d    = err_q;
      ferr_d   = ferr_q;
      ovr_d    = ovr_q;
      load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               tick_d  = '0;
            end
         end
         START: begin
            if (tick_q == TICK_MID) begin
               tick_d  = '0;
               idx_d   = '0;
               // A line already back high at mid-start was only a glitch
               state_d = rxs ? IDLE : DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         DATA: begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         PARITY: begin
            if (tick_q == TICK_LAST) begin
               tick_d   = '0;
               par_ok_d = ((^shift_q) ^ rxs) == PARITY_ODD;
               state_d  = STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         STOP: begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               load    = 1'b1;
               // A low stop bit may be a break; wait for the line to rise
               state_d = rxs ? IDLE : WAIT_HIGH;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rxs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new word wins over a same-cycle accept of the old one
      if (load) begin
         data_d  = shift_q;
         err_d   = ~par_ok_q;
         ferr_d  = ~rxs;
         ovr_d   = valid_q & ~rx_ready;
         valid_d = 1'b1;
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
         err_d   = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // State, counters and holding register
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         par_ok_q <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_ok_q <= par_ok_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign rx_data        = data_q;
   assign rx_valid       = valid_q;
   assign rx_error       = err_q;
   assign rx_frame_error = ferr_q;
   assign rx_overrun     = ovr_q;
   assign rx_busy        = (state_q != IDLE);

endmodule
